// File: rtl/result_uart_tx.sv
// result_uart_tx: latches the three 16-bit results from the distance stage on its
// completion pulse, frames them as an 8-byte packet (header, 6 payload bytes,
// XOR checksum) and sends the packet LSB-first on a UART 8N1 line.
module result_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter logic [7:0]  HEADER       = 8'hAA
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [15:0] lowest,
    input  logic [15:0] highest,
    input  logic [15:0] hitvector,
    input  logic        flashin,
    output logic        tx,
    output logic        busy,
    output logic        overrun
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } state_e;

    // Last value of the baud counter before the current bit period ends.
    localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

    state_e           state_q,    state_d;
    logic [15:0]      baud_q,     baud_d;
    logic [2:0]       bit_idx_q,  bit_idx_d;
    logic [2:0]       byte_idx_q, byte_idx_d;
    logic [7:0][7:0]  pkt_q,      pkt_d;      // pkt_q[0] is sent first
    logic             tx_q,       tx_d;
    logic             busy_q,     busy_d;
    logic             overrun_q,  overrun_d;

    logic             baud_done;
    logic [7:0]       chk;

    // Checksum over the six payload bytes; the header is deliberately excluded.
    assign chk = lowest[7:0] ^ lowest[15:8] ^ highest[7:0] ^ highest[15:8]
               ^ hitvector[7:0] ^ hitvector[15:8];

    assign baud_done = (baud_q == BAUD_LAST);

    // Next-state, counter, packet-latch and registered-output computation.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
        state_d    = state_q;
        baud_d     = baud_q;
        bit_idx_d  = bit_idx_q;
        byte_idx_d = byte_idx_q;
        pkt_d      = pkt_q;
        overrun_d  = overrun_q;

        unique case (state_q)
            IDLE: begin
                if (flashin) begin
                    pkt_d      = {chk, hitvector[15:8], hitvector[7:0],
                                  highest[15:8], highest[7:0],
                                  lowest[15:8], lowest[7:0], HEADER};
                    state_d    = START;
                    byte_idx_d = 3'd0;
                    bit_idx_d  = 3'd0;
                    baud_d     = 16'd0;
                end
            end
            START: begin
                if (baud_done) begin
                    state_d   = DATA;
                    bit_idx_d = 3'd0;
                    baud_d    = 16'd0;
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            DATA: begin
                if (baud_done) begin
                    baud_d = 16'd0;
                    if (bit_idx_q == 3'd7) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                    end
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            STOP: begin
                if (baud_done) begin
                    baud_d = 16'd0;
                    if (byte_idx_q == 3'd7) begin
                        state_d = IDLE;
                    end else begin
                        byte_idx_d = byte_idx_q + 3'd1;
                        state_d    = START;
                    end
                end else begin
                    baud_d = baud_q + 16'd1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Any pulse that lands outside IDLE is dropped and remembered until reset.
        if (flashin && (state_q != IDLE)) begin
            overrun_d = 1'b1;
        end

        // Outputs are derived from the next state so they register on the same edge.
        unique case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = pkt_q[byte_idx_d][bit_idx_d];
            default: tx_d = 1'b1;
        endcase
        busy_d = (state_d != IDLE);
    end

    // State register with synchronous reset; reset aborts any packet in flight.
    always_ff @(posedge clock) begin
        if (reset) begin
            // NOTE: the packet store is cleared with the rest of the state so a fresh
            // start never exposes stale bytes; it is small enough to live in flops.
            state_q    <= IDLE;
            baud_q     <= 16'd0;
            bit_idx_q  <= 3'd0;
            byte_idx_q <= 3'd0;
            pkt_q      <= '0;
            tx_q       <= 1'b1;
            busy_q     <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling pre-edge values.
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_idx_q  <= bit_idx_d;
            byte_idx_q <= byte_idx_d;
            pkt_q      <= pkt_d;
            tx_q       <= tx_d;
            busy_q     <= busy_d;
            overrun_q  <= overrun_d;
        end
    end

    assign tx      = tx_q;
    assign busy    = busy_q;
    assign overrun = overrun_q;

endmodule

// File: tb/tb_result_uart_tx.sv
// tb_result_uart_tx: directed stimulus pushes expected packet bytes into a queue;
// an independent mid-bit UART decoder pops and compares every received byte.
module tb_result_uart_tx;

    localparam int CPB      = 4;
    localparam int PKT_CYC  = 80 * CPB;

    logic        clock;
    logic        reset;
    logic [15:0] lowest;
    logic [15:0] highest;
    logic [15:0] hitvector;
    logic        flashin;
    logic        tx;
    logic        busy;
    logic        overrun;

    int n_checks = 0;
    int n_errors = 0;

    logic [7:0] exp_q[$];

    result_uart_tx #(
        .CLKS_PER_BIT(CPB),
        .HEADER      (8'hAA)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .lowest   (lowest),
        .highest  (highest),
        .hitvector(hitvector),
        .flashin  (flashin),
        .tx       (tx),
        .busy     (busy),
        .overrun  (overrun)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Packet given as 64 bits with byte 0 (header) in the top byte.
    task automatic push_packet(input logic [63:0] p);
        for (int i = 0; i < 8; i++) begin
            exp_q.push_back(p[63 - 8*i -: 8]);
        end
    endtask

    // One-cycle flashin pulse; on return the accepting edge has just passed.
    task automatic pulse(input logic [15:0] lo, input logic [15:0] hi, input logic [15:0] hv);
        lowest    = lo;
        highest   = hi;
        hitvector = hv;
        flashin   = 1'b1;
        tick();
        flashin   = 1'b0;
    endtask

    // Count cycles until busy drops, bounded so the run always ends.
    task automatic wait_idle(output int cycles);
        cycles = 0;
        while (busy === 1'b1 && cycles < 1000) begin
            tick();
            cycles++;
        end
    endtask

    // Mid-bit UART decoder and scoreboard consumer, sampling on falling edges.
    logic       rx_active = 1'b0;
    int         rx_ofs    = 0;
    logic [7:0] rx_byte   = 8'h00;
    logic [7:0] rx_exp;

    always @(negedge clock) begin
        if (reset !== 1'b0) begin
            rx_active = 1'b0;
        end else if (!rx_active) begin
            if (tx === 1'b0) begin
                rx_active = 1'b1;
                rx_ofs    = 0;
            end
        end else begin
            rx_ofs++;
            if (rx_ofs == 2) begin
                check("start_bit", 64'(tx), 64'd0);
            end else if (rx_ofs >= 6 && rx_ofs <= 34 && ((rx_ofs - 6) % 4) == 0) begin
                rx_byte[(rx_ofs - 6) / 4] = tx;
            end else if (rx_ofs == 38) begin
                check("stop_bit", 64'(tx), 64'd1);
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL unexpected_byte: got %0h expected none at %0t", rx_byte, $time);
                end else begin
                    rx_exp = exp_q.pop_front();
                    check("rx_byte", 64'(rx_byte), 64'(rx_exp));
                end
                rx_active = 1'b0;
            end
        end
    end

    initial begin
        int cyc;
        int bad;

        reset     = 1'b1;
        flashin   = 1'b0;
        lowest    = 16'h0000;
        highest   = 16'h0000;
        hitvector = 16'h0000;

        // Reset for three cycles, then a quiet line for 100 cycles.
        repeat (3) tick();
        check("reset_tx", 64'(tx), 64'd1);
        check("reset_busy", 64'(busy), 64'd0);
        check("reset_overrun", 64'(overrun), 64'd0);
        reset = 1'b0;
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            tick();
            if (tx !== 1'b1 || busy !== 1'b0 || overrun !== 1'b0) bad++;
        end
        check("idle_quiet_cycles", 64'(bad), 64'd0);

        // Single packet.
        push_packet(64'hAA_23_01_67_45_AB_89_22);
        pulse(16'h0123, 16'h4567, 16'h89AB);
        check("single_tx_fall", 64'(tx), 64'd0);
        check("single_busy_rise", 64'(busy), 64'd1);
        wait_idle(cyc);
        check("single_busy_len", 64'(cyc), 64'(PKT_CYC));
        check("single_overrun", 64'(overrun), 64'd0);
        repeat (5) tick();

        // Same data, inputs changed to all-ones right after acceptance.
        push_packet(64'hAA_23_01_67_45_AB_89_22);
        pulse(16'h0123, 16'h4567, 16'h89AB);
        lowest    = 16'hFFFF;
        highest   = 16'hFFFF;
        hitvector = 16'hFFFF;
        wait_idle(cyc);
        check("stable_busy_len", 64'(cyc), 64'(PKT_CYC - 1 + 1));
        repeat (5) tick();

        // Overrun: second pulse 50 cycles into the packet is dropped.
        push_packet(64'hAA_34_12_78_56_BC_9A_2E);
        pulse(16'h1234, 16'h5678, 16'h9ABC);
        repeat (49) tick();
        check("pre_overrun", 64'(overrun), 64'd0);
        pulse(16'h5555, 16'hAAAA, 16'h0F0F);
        check("overrun_set", 64'(overrun), 64'd1);
        wait_idle(cyc);
        check("overrun_busy_len", 64'(cyc), 64'(PKT_CYC - 50));
        bad = 0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        check("no_second_packet", 64'(bad), 64'd0);
        check("overrun_sticky", 64'(overrun), 64'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("overrun_cleared", 64'(overrun), 64'd0);

        // flashin coinciding with reset is ignored.
        reset   = 1'b1;
        flashin = 1'b1;
        tick();
        reset   = 1'b0;
        flashin = 1'b0;
        check("rst_flash_busy", 64'(busy), 64'd0);
        check("rst_flash_overrun", 64'(overrun), 64'd0);
        repeat (3) tick();
        check("rst_flash_tx", 64'(tx), 64'd1);

        // Back-to-back: second pulse on the first idle cycle.
        push_packet(64'hAA_00_00_00_00_00_00_00);
        pulse(16'h0000, 16'h0000, 16'h0000);
        wait_idle(cyc);
        check("b2b_first_len", 64'(cyc), 64'(PKT_CYC));
        check("b2b_gap_tx", 64'(tx), 64'd1);
        push_packet(64'hAA_FF_FF_FF_FF_FF_FF_00);
        pulse(16'hFFFF, 16'hFFFF, 16'hFFFF);
        check("b2b_second_tx_fall", 64'(tx), 64'd0);
        check("b2b_second_busy", 64'(busy), 64'd1);
        wait_idle(cyc);
        check("b2b_second_len", 64'(cyc), 64'(PKT_CYC));
        repeat (5) tick();

        // Reset during DATA of byte 3 (byte 3 data starts 124 cycles in).
        push_packet(64'hAA_23_01_67_45_AB_89_22);
        pulse(16'h0123, 16'h4567, 16'h89AB);
        repeat (130) tick();
        check("midframe_bytes_left", 64'(exp_q.size()), 64'd5);
        exp_q.delete();
        reset = 1'b1;
        tick();
        check("midframe_rst_tx", 64'(tx), 64'd1);
        check("midframe_rst_busy", 64'(busy), 64'd0);
        reset = 1'b0;
        repeat (10) tick();
        push_packet(64'hAA_FF_00_0F_0F_01_80_7E);
        pulse(16'h00FF, 16'h0F0F, 16'h8001);
        wait_idle(cyc);
        check("after_rst_len", 64'(cyc), 64'(PKT_CYC));
        repeat (10) tick();

        check("scoreboard_empty", 64'(exp_q.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/result_uart_tx.md
Name: result_uart_tx

Overview:
- Downstream consumer of the distance processing stage.
- On that stage's one-cycle completion pulse, latches its three 16-bit results (lowest, highest, hitvector) and frames them into a fixed 8-byte packet: header, 6 payload bytes, XOR checksum.
- Serialises the packet on a UART 8N1 line back to the host, closing the AGV UART loop.

Parameters:
- CLKS_PER_BIT, 434, clock cycles per UART bit (50 MHz / 115200); legal range 2..65535.
- HEADER, 8'hAA, first byte of every packet.

Ports:
- clock  input  1  system clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- lowest  input  16  lowest-distance result, sampled only on an accepted flashin.
- highest  input  16  highest-distance result, sampled only on an accepted flashin.
- hitvector  input  16  hit bitmap, sampled only on an accepted flashin.
- flashin  input  1  one-cycle "results valid" pulse from the distance stage.
- tx  output  1  UART serial line; idle high.
- busy  output  1  high while a packet is being transmitted.
- overrun  output  1  sticky flag; a flashin arrived while busy.

Behaviour:
- Reset (reset=1 at a rising edge) forces, on that edge:
  - outputs: tx=1, busy=0, overrun=0.
  - internal: state=IDLE, all counters 0, latched bytes 0.
- Reset mid-packet aborts immediately; no partial byte completes.
- Packet order, byte 0 to byte 7:
  - HEADER, lowest[7:0], lowest[15:8], highest[7:0], highest[15:8], hitvector[7:0], hitvector[15:8], CHK.
  - CHK = XOR of bytes 1..6; HEADER is not included.
- Packet latch: all 8 bytes, including CHK, are computed and stored on the accepting edge. Later input changes have no effect on the packet in flight.
- State machine:
  - IDLE: tx=1, busy=0. flashin=1 latches the packet, sets byte_idx=0, and moves to START.
  - START: tx=0 for CLKS_PER_BIT cycles, then DATA with bit_idx=0.
  - DATA: tx=current_byte[bit_idx], LSB first. Each bit is held CLKS_PER_BIT cycles. After bit 7, go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles. Then:
    - byte_idx<7: byte_idx+1 and go to START, with no inter-byte gap.
    - byte_idx=7: go to IDLE.
- Baud counter: counts 0..CLKS_PER_BIT-1, resets to 0 on every state or bit change, with no drift across bytes.
- Latency: if flashin is high at edge N, then from edge N+1:
  - tx=0 and busy=1;
  - the line is active for exactly 80*CLKS_PER_BIT cycles;
  - busy falls at edge N+1+80*CLKS_PER_BIT, together with the return to IDLE.
- busy is high in START, DATA and STOP, and low only in IDLE.
- flashin while busy=1, including the final stop-bit cycle: the pulse is ignored, the packet in flight is unchanged, and overrun is set to 1 on the next edge. overrun stays 1 until reset.
- flashin held high for multiple cycles in IDLE: only the first cycle is accepted. The following cycles fall in busy and set overrun.
- flashin at the same edge as reset=1: reset wins; no packet is sent and overrun stays 0.
- Back-to-back packets: a flashin on the first IDLE cycle after a packet ends is accepted normally. tx then stays high for exactly that one cycle between packets.
- No other outputs change while transmitting. tx is a registered output; it carries no combinational path from inputs.

Test Plan (bench uses CLKS_PER_BIT=4):
- Reset check: assert reset 3 cycles, then hold flashin=0 for 100 cycles -> tx=1, busy=0, overrun=0 throughout.
- Single packet, lowest=16'h0123, highest=16'h4567, hitvector=16'h89AB, flashin pulsed 1 cycle -> bench UART decoder (sampling mid-bit) reads AA 23 01 67 45 AB 89 22.
  - tx falls 1 cycle after the pulse.
  - busy is high for exactly 320 cycles.
  - overrun stays 0.
- Input stability: after that flashin, change all data inputs to 16'hFFFF on the next cycle -> the same 8 bytes are transmitted unchanged.
- Overrun: pulse flashin again 50 cycles into the packet with different data -> the original packet completes unchanged, overrun=1 from the following edge, no second packet. Assert reset -> overrun=0.
- Back-to-back: pulse flashin on the first cycle busy=0 after a packet of all zeros (bytes AA 00 00 00 00 00 00 00) -> exactly 1 idle-high cycle, then a second packet. For lowest=highest=hitvector=16'hFFFF the second packet decodes AA FF FF FF FF FF FF 00.
- Reset mid-frame: assert reset during DATA of byte 3 -> tx=1 and busy=0 on that edge. A later flashin sends a complete, correct packet.
